tank_access_sequencer: RTL and testbench
========================================

TANK_ACCESS_SEQUENCER -- requirements
Module: tank_access_sequencer

Interface
REQ-001 The block SHALL have parameter MC_LEN, default 18, meaning clock cycles per minor cycle (word slot).
REQ-002 The block SHALL have parameter TMO_LEN, default 64, meaning watchdog limit in clocks (used only with TANK_SEQ_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port mc_start  input  1  one-clock pulse marking the first pulse position of a minor cycle.
REQ-006 The block SHALL have port req  input  2  per-requester access request; bit0 = order fetch, bit1 = operand.
REQ-007 The block SHALL have port wr  input  2  per-requester direction, 1 = write to tank (t_in), 0 = read (t_out); bit0 ignored, order fetch is always a read.
REQ-008 The block SHALL have port tsel0, tsel1  input  2 each  tank number 0..3 for requester 0 and requester 1.
REQ-009 The block SHALL have ports f7_pos, f7_neg, f8_pos, f8_neg  output  1 each  complementary tank-select lines for the r2_up tank decoder; f7 = tank bit0, f8 = tank bit1.
REQ-010 The block SHALL have ports t_in, t_out  output  1 each  tank write and read strobes.
REQ-011 The block SHALL have ports grant, done  output  2 each  one-hot grant held for the transfer; one-clock done pulse.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 The block SHALL have port err  output  1  sticky timeout flag; tied 0 when the feature is compiled out.

Function
REQ-014 The block SHALL implement states IDLE, WAIT_MC, XFER, DONE.
REQ-015 In IDLE with any req bit set, the block SHALL pick a winner by two-way round-robin, register its tank, direction and grant, and go to WAIT_MC next clock.
REQ-016 Round-robin: when both request, the requester not served last wins; after reset requester 1 has priority.
REQ-017 In WAIT_MC the block SHALL drive f7/f8 from the latched tank and go to XFER on the clock after mc_start.
REQ-018 A mc_start seen in the same clock as the IDLE->WAIT_MC transition SHALL NOT start the transfer; the next mc_start does.
REQ-019 In XFER the block SHALL assert exactly one of t_in/t_out for exactly MC_LEN clocks, counted by a bit counter 0..MC_LEN-1.
REQ-020 At counter value MC_LEN-1 the block SHALL go to DONE; in DONE it SHALL pulse done[winner] for one clock, clear grant, and return to IDLE.
REQ-021 Outside WAIT_MC/XFER, f7_pos/f8_pos SHALL be 0 and f7_neg/f8_neg SHALL be 0 (no tank selected); in them, x_neg = ~x_pos always.
REQ-022 Deasserting req while granted SHALL NOT abort the transfer; new req/tsel changes are ignored until IDLE.
REQ-023 Back-to-back: a request pending during DONE SHALL be arbitrated in the following IDLE clock (minimum one idle clock between transfers).
REQ-024 mc_start during XFER SHALL be ignored.

Reset
REQ-025 While rst is high all outputs SHALL be 0, state IDLE, counter 0, round-robin pointer = requester 1 first, err cleared.
REQ-026 Reset mid-transfer SHALL drop t_in/t_out immediately (asynchronously) without a done pulse.

Configuration
REQ-027 With TANK_SEQ_TIMEOUT_EN defined, a watchdog SHALL count clocks in WAIT_MC; reaching TMO_LEN without mc_start SHALL set err, pulse done[winner], and return to IDLE without strobing t_in/t_out.
REQ-028 Without TANK_SEQ_TIMEOUT_EN the block SHALL wait in WAIT_MC indefinitely and err SHALL be constant 0.

Structure
REQ-029 The state enumeration, requester index constants and default MC_LEN SHALL reside in the shared package edsac_ctrl_pkg.
REQ-030 The minor-cycle bit counter SHALL be a sub-module tank_seq_bitcnt (enable, clear, terminal-count output).

Verification
REQ-031 The bench SHALL drive req=2'b10, wr[1]=1, tsel1=3, then mc_start 5 clocks later; it SHALL check f7_pos=f8_pos=1, t_in high exactly 18 clocks starting the clock after mc_start, then done=2'b10 for one clock.
REQ-032 The bench SHALL drive req=2'b11 continuously; it SHALL check grants alternate 10,01,10,01 and that requester 0 transfers use t_out only.
REQ-033 The bench SHALL pulse mc_start in the same clock as the IDLE->WAIT_MC transition; it SHALL check that XFER starts only after the next mc_start.
REQ-034 The bench SHALL assert rst at count 7 of XFER; it SHALL check t_out=0 immediately, no done pulse, and busy=0.
REQ-035 With TANK_SEQ_TIMEOUT_EN and TMO_LEN=64, the bench SHALL grant with no mc_start; it SHALL check err=1 after 64 clocks, done pulse, no strobes, and err held until rst.
REQ-036 The bench SHALL drop req and change tsel1 from 2 to 1 during XFER; it SHALL check that the select lines stay at tank 2 (f7_pos=0, f8_pos=1) until DONE.

Source files
------------

// File: rtl/edsac_ctrl_pkg.sv
// Shared control definitions for the tank access path.
//   tank_seq_state_e : sequencer states IDLE / WAIT_MC / XFER / DONE
//   REQ_ORDER/OPND   : requester indices (bit positions in req/wr/grant/done)
//   MC_LEN_DEF       : default clocks per minor cycle (one word slot)
//   tank_xfer_t      : transfer context latched at arbitration
//   rr_pick()        : two-way round-robin winner select
package edsac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_MC = 2'd1,
    XFER    = 2'd2,
    DONE    = 2'd3
  } tank_seq_state_e;

  localparam int REQ_ORDER  = 0;
  localparam int REQ_OPND   = 1;
  localparam int MC_LEN_DEF = 18;

  typedef struct packed {
    logic       win;   // winning requester index
    logic       dir;   // 1 = write (t_in), 0 = read (t_out)
    logic [1:0] tank;  // tank number 0..3
  } tank_xfer_t;

  // prio names the requester that wins a tie; a lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic prio);
    if (req[REQ_ORDER] && req[REQ_OPND]) return prio;
    return req[REQ_OPND];
  endfunction

endpackage

// File: rtl/tank_seq_bitcnt.sv
// Minor-cycle bit counter: counts 0..N-1 while enabled.
//   clk, rst : clock, async active-high reset
//   en       : count this clock
//   clr      : synchronous clear (wins over en)
//   tc       : terminal count, high while enabled at value N-1
module tank_seq_bitcnt
  import edsac_ctrl_pkg::*;
#(
  parameter int N = MC_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;

  assign tc = en && (cnt_q == W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= tc ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/tank_access_sequencer.sv
// Tank access sequencer: arbitrates order-fetch (req[0]) and operand (req[1])
// access to the delay-line tanks, selects the tank through f7/f8, waits for
// the next minor-cycle start and strobes t_in or t_out for one minor cycle.
//   clk, rst           : clock, async active-high reset
//   mc_start           : one-clock pulse at first pulse position of a minor cycle
//   req, wr            : per-requester request / direction (wr[0] ignored)
//   tsel0, tsel1       : tank numbers for requester 0 / 1
//   f7_*, f8_*         : complementary tank-select lines (f7 = bit0, f8 = bit1)
//   t_in, t_out        : tank write / read strobes
//   grant, done        : one-hot grant for the transfer / one-clock done pulse
//   busy               : not IDLE
//   err                : sticky WAIT_MC timeout
// Build option: define TANK_SEQ_TIMEOUT_EN to enable the WAIT_MC watchdog
// (TMO_LEN clocks); without it WAIT_MC waits forever and err is 0.
module tank_access_sequencer
  import edsac_ctrl_pkg::*;
#(
  parameter int MC_LEN  = MC_LEN_DEF,
  parameter int TMO_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mc_start,
  input  logic [1:0] req,
  input  logic [1:0] wr,
  input  logic [1:0] tsel0,
  input  logic [1:0] tsel1,
  output logic       f7_pos,
  output logic       f7_neg,
  output logic       f8_pos,
  output logic       f8_neg,
  output logic       t_in,
  output logic       t_out,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic       err
);

  tank_seq_state_e state_q, state_d;
  tank_xfer_t      xfer_q, xfer_d;
  logic [1:0]      grant_q, grant_d;
  logic            prio_q, prio_d;
  logic            win_pick;
  logic            cnt_tc;
  logic            tmo_hit;
  logic            sel_on;

  assign win_pick = rr_pick(req, prio_q);

  tank_seq_bitcnt #(.N(MC_LEN)) u_bitcnt (
    .clk (clk),
    .rst (rst),
    .en  (state_q == XFER),
    .clr (state_q != XFER),
    .tc  (cnt_tc)
  );

`ifdef TANK_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_LEN) + 1;

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // Fires on the TMO_LEN-th clock spent in WAIT_MC; mc_start on that clock wins.
  assign tmo_hit = (state_q == WAIT_MC) && (wd_q == WD_W'(TMO_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == WAIT_MC) ? wd_q + 1'b1 : '0;
      if (tmo_hit && !mc_start) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Watchdog compiled out: never true, keeps TMO_LEN referenced.
  assign tmo_hit = (TMO_LEN < 0);
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          xfer_d.win  = win_pick;
          xfer_d.tank = win_pick ? tsel1 : tsel0;
          // Order fetch is always a read, so only the operand's wr counts.
          xfer_d.dir  = win_pick & wr[win_pick];
          grant_d           = '0;
          grant_d[win_pick] = 1'b1;
          prio_d      = ~win_pick;
          state_d     = WAIT_MC;
        end
      end
      WAIT_MC: begin
        if (mc_start) begin
          state_d = XFER;
        end else if (tmo_hit) begin
          state_d = DONE;
          grant_d = '0;
        end
      end
      XFER: begin
        if (cnt_tc) begin
          state_d = DONE;
          grant_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xfer_q  <= '0;
      grant_q <= '0;
      prio_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Outputs decode registered state only, so async reset drops them at once.
  assign sel_on = (state_q == WAIT_MC) || (state_q == XFER);
  assign f7_pos = sel_on &  xfer_q.tank[0];
  assign f7_neg = sel_on & ~xfer_q.tank[0];
  assign f8_pos = sel_on &  xfer_q.tank[1];
  assign f8_neg = sel_on & ~xfer_q.tank[1];
  assign t_in   = (state_q == XFER) &  xfer_q.dir;
  assign t_out  = (state_q == XFER) & ~xfer_q.dir;
  assign grant  = grant_q;
  assign busy   = (state_q != IDLE);

  always_comb begin
    done = '0;
    done[xfer_q.win] = (state_q == DONE);
  end

endmodule

// File: tb/tb_tank_access_sequencer.sv
// Directed bench for tank_access_sequencer (MC_LEN=18, TMO_LEN=64).
module tb_tank_access_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mc_start = 1'b0;
  logic [1:0] req = '0, wr = '0, tsel0 = '0, tsel1 = '0;
  logic       f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, busy, err;
  logic [1:0] grant, done;

  int n_chk = 0;
  int n_fail = 0;

  tank_access_sequencer #(.MC_LEN(18), .TMO_LEN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .req      (req),
    .wr       (wr),
    .tsel0    (tsel0),
    .tsel1    (tsel1),
    .f7_pos   (f7_pos),
    .f7_neg   (f7_neg),
    .f8_pos   (f8_pos),
    .f8_neg   (f8_neg),
    .t_in     (t_in),
    .t_out    (t_out),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end expected end of test");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; req = '0; wr = '0; tsel0 = '0; tsel1 = '0; mc_start = 1'b0;
    tick();
    tick();
    chk({tag, "_rst_out"},
        {f7_pos, f7_neg, f8_pos, f8_neg, t_in, t_out, grant, done, busy, err}, '0);
    rst = 1'b0;
  endtask

  // Wait for grant, check selects, wait n_wait clocks, pulse mc_start and
  // watch 40 clocks of strobes / done.
  task automatic run_xfer(input string tag, input logic [1:0] eg, input logic ewr,
                          input logic [1:0] etank, input int n_wait, input bit perturb);
    bit seen;
    int in_cnt, out_cnt, first, dn_cnt, sel_bad;
    logic [1:0] dn_val;
    seen = 0; in_cnt = 0; out_cnt = 0; first = -1; dn_cnt = 0; sel_bad = 0; dn_val = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (grant != 2'b00) seen = 1;
      else tick();
    end
    chk({tag, "_grant"}, grant, eg);
    chk({tag, "_sel"}, {f7_pos, f7_neg, f8_pos, f8_neg},
        {etank[0], ~etank[0], etank[1], ~etank[1]});
    repeat (n_wait) tick();
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (perturb && i == 3) begin
        req = '0;
        tsel1 = 2'd1;
      end
      if (t_in || t_out) begin
        if (first < 0) first = i;
        in_cnt += int'(t_in);
        out_cnt += int'(t_out);
        if ({f7_pos, f7_neg, f8_pos, f8_neg} != {etank[0], ~etank[0], etank[1], ~etank[1]})
          sel_bad++;
      end
      if (done != 2'b00) begin
        dn_cnt++;
        dn_val = done;
      end
      tick();
    end
    chk({tag, "_first"},   first, 0);
    chk({tag, "_t_in"},    in_cnt, ewr ? 18 : 0);
    chk({tag, "_t_out"},   out_cnt, ewr ? 0 : 18);
    chk({tag, "_sel_hold"}, sel_bad, 0);
    chk({tag, "_done_n"},  dn_cnt, 1);
    chk({tag, "_done_v"},  dn_val, eg);
  endtask

  initial begin
    int strobes, dn_cnt, ef;

    // Single operand write to tank 3.
    do_reset("t1");
    req = 2'b10; wr = 2'b10; tsel1 = 2'd3;
    tick();
    req = '0;
    chk("t1_busy", busy, 1);
    run_xfer("t1", 2'b10, 1'b1, 2'd3, 4, 0);
    chk("t1_idle", busy, 0);
    chk("t1_err", err, 0);

    // Both requesting: strict alternation, order fetch reads even with wr[0]=1.
    do_reset("t2");
    req = 2'b11; wr = 2'b11; tsel0 = 2'd1; tsel1 = 2'd2;
    run_xfer("t2a", 2'b10, 1'b1, 2'd2, 1, 0);
    run_xfer("t2b", 2'b01, 1'b0, 2'd1, 1, 0);
    run_xfer("t2c", 2'b10, 1'b1, 2'd2, 1, 0);
    run_xfer("t2d", 2'b01, 1'b0, 2'd1, 1, 0);

    // mc_start on the arbitration clock must not start the transfer.
    do_reset("t3");
    req = 2'b10; wr = 2'b10; tsel1 = 2'd1; mc_start = 1'b1;
    tick();
    mc_start = 1'b0; req = '0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      strobes += int'(t_in) + int'(t_out);
      tick();
    end
    chk("t3_no_early", strobes, 0);
    chk("t3_wait", busy, 1);
    run_xfer("t3", 2'b10, 1'b1, 2'd1, 0, 0);

    // Reset at count 7 of a read transfer.
    do_reset("t4");
    req = 2'b01; tsel0 = 2'd2;
    tick();
    req = '0;
    chk("t4_grant", grant, 2'b01);
    mc_start = 1'b1;
    tick();
    mc_start = 1'b0;
    repeat (7) tick();
    chk("t4_pre", t_out, 1);
    rst = 1'b1;
    #1;
    chk("t4_t_out", t_out, 0);
    chk("t4_busy", busy, 0);
    chk("t4_grant0", grant, 0);
    dn_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (done != 2'b00) dn_cnt++;
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done != 2'b00) dn_cnt++;
      tick();
    end
    chk("t4_no_done", dn_cnt, 0);
    chk("t4_idle", busy, 0);

    // req drop and tsel1 change during XFER are ignored.
    do_reset("t6");
    req = 2'b10; wr = 2'b00; tsel1 = 2'd2;
    tick();
    run_xfer("t6", 2'b10, 1'b0, 2'd2, 2, 1);
    chk("t6_idle", busy, 0);

`ifdef TANK_SEQ_TIMEOUT_EN
    // No mc_start: watchdog expires after 64 clocks in WAIT_MC.
    do_reset("t5");
    req = 2'b10; wr = 2'b10; tsel1 = 2'd3;
    tick();
    req = '0;
    ef = -1; strobes = 0; dn_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (err && ef < 0) ef = i;
      strobes += int'(t_in) + int'(t_out);
      if (done == 2'b10) dn_cnt++;
      tick();
    end
    chk("t5_err_at", ef, 64);
    chk("t5_strobes", strobes, 0);
    chk("t5_done", dn_cnt, 1);
    chk("t5_err_held", err, 1);
    chk("t5_idle", busy, 0);
    do_reset("t5_clr");
`else
    // No watchdog: WAIT_MC holds indefinitely and err stays 0.
    do_reset("t5");
    req = 2'b10; wr = 2'b10; tsel1 = 2'd3;
    tick();
    req = '0;
    ef = 0;
    for (int i = 0; i < 80; i++) begin
      if (err || !busy || t_in || t_out) ef++;
      tick();
    end
    chk("t5_wait_forever", ef, 0);
    do_reset("t5_clr");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
